// File: rtl/maze_ram_drawer.sv
// Scans the 32x32 maze RAM in row-major order and paints each cell as a
// CELL_PX x CELL_PX block on the VGA adapter, one pixel per cycle.
module maze_ram_drawer #(
    parameter int CELL_PX     = 3,
    parameter int X_OFFSET    = 32,
    parameter int Y_OFFSET    = 12,
    parameter int RAM_LATENCY = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    output logic [9:0] ram_address,
    input  logic [2:0] ram_data,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    // state | meaning
    // IDLE  | waiting for start
    // FETCH | address {cy,cx} presented, waiting RAM_LATENCY cycles for data
    // PAINT | plotting CELL_PX^2 pixels of the current cell
    // DONE  | one-cycle done pulse after the last pixel of the frame
    typedef enum logic [1:0] {IDLE, FETCH, PAINT, DONE} state_t;

    localparam int FW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

    state_t        state, state_n;
    logic [4:0]    cx, cy, cx_n, cy_n;
    logic [1:0]    px, py, px_n, py_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic          latch;
    logic [7:0]    x_n;
    logic [6:0]    y_n;

    always_comb begin
        state_n = state;
        cx_n    = cx;
        cy_n    = cy;
        px_n    = px;
        py_n    = py;
        fcnt_n  = fcnt;
        latch   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                    cx_n    = 5'd0;
                    cy_n    = 5'd0;
                    fcnt_n  = FW'(RAM_LATENCY - 1);
                end
            end
            FETCH: begin
                if (fcnt == '0) begin
                    latch   = 1'b1;
                    state_n = PAINT;
                    px_n    = 2'd0;
                    py_n    = 2'd0;
                end else begin
                    fcnt_n = fcnt - 1'b1;
                end
            end
            PAINT: begin
                if (px == 2'(CELL_PX - 1)) begin
                    px_n = 2'd0;
                    if (py == 2'(CELL_PX - 1)) begin
                        py_n = 2'd0;
                        if ({cy, cx} == 10'h3FF) begin
                            state_n = DONE;
                        end else begin
                            {cy_n, cx_n} = {cy, cx} + 10'd1;
                            state_n      = FETCH;
                            fcnt_n       = FW'(RAM_LATENCY - 1);
                        end
                    end else begin
                        py_n = py + 2'd1;
                    end
                end else begin
                    px_n = px + 2'd1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pixel coordinates are computed from next-state counters so the
    // registered outputs line up with the registered state.
    always_comb begin
        x_n = 8'(X_OFFSET) + 8'(cx_n) * 8'(CELL_PX) + 8'(px_n);
        y_n = 7'(Y_OFFSET) + 7'(cy_n) * 7'(CELL_PX) + 7'(py_n);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            cx          <= 5'd0;
            cy          <= 5'd0;
            px          <= 2'd0;
            py          <= 2'd0;
            fcnt        <= '0;
            ram_address <= 10'd0;
            vga_x       <= 8'd0;
            vga_y       <= 7'd0;
            vga_colour  <= 3'd0;
            vga_plot    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cx          <= cx_n;
            cy          <= cy_n;
            px          <= px_n;
            py          <= py_n;
            fcnt        <= fcnt_n;
            ram_address <= {cy_n, cx_n};
            if (latch)
                vga_colour <= ram_data;
            vga_plot    <= (state_n == PAINT);
            busy        <= (state_n == FETCH) || (state_n == PAINT);
            done        <= (state_n == DONE);
            vga_x       <= (state_n == PAINT) ? x_n : 8'd0;
            vga_y       <= (state_n == PAINT) ? y_n : 7'd0;
        end
    end

endmodule
